// File: rtl/arb_pkg.sv
// arb_pkg: shared state type, default parameters and index-width helper for the arbiter
package arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_e;
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int TIMEOUT_CYCLES_DEF = 255;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first set request at or after the pointer, searched cyclically
module rr_priority_picker import arb_pkg::*; #(
  parameter int N = NUM_REQ_DEF,
  parameter int IW = idx_w(NUM_REQ_DEF)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);
  // walk offsets from farthest to nearest so the nearest valid requester wins
  always_comb begin
    grant_o = '0;
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        grant_o = '0;
        grant_o[(int'(ptr_i) + k) % N] = 1'b1;
        idx_o = IW'((int'(ptr_i) + k) % N);
      end
    end
  end
endmodule

// File: rtl/rr_compute_arbiter.sv
// rr_compute_arbiter: round-robin sharing of one compute datapath among requesters
module rr_compute_arbiter import arb_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          dp_start_o,
  output logic [DATA_WIDTH-1:0]         dp_operand_o,
  input  logic                          dp_done_i,
  input  logic [DATA_WIDTH-1:0]         dp_result_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          rsp_error_o,
  output logic [idx_w(NUM_REQ)-1:0]     grant_id_o,
  output logic                          busy_o
);
  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, gid_q, gid_d, pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic [DATA_WIDTH-1:0] op_q, op_d, res_q, res_d;
  logic err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic resp;
  rr_priority_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i(req_valid_i),
    .ptr_i(ptr_q),
    .grant_o(pick_grant),
    .idx_o(pick_idx)
  );
  // next-state: accept in IDLE, pulse start, wait for done or timeout (done wins a tie), respond
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gid_d = gid_q;
    op_d = op_q;
    res_d = res_q;
    err_d = err_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: if (|req_valid_i) begin
        state_d = S_ISSUE;
        gid_d = pick_idx;
        op_d = req_data_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d = '0;
      end
      S_WAIT: if (dp_done_i) begin
        state_d = S_RESPOND;
        res_d = dp_result_i;
        err_d = 1'b0;
      end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d = S_RESPOND;
        res_d = '0;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ptr_d = (gid_q == IW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
      end
    endcase
  end
  // state register with synchronous reset clearing every stored value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      gid_q <= '0;
      op_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gid_q <= gid_d;
      op_q <= op_d;
      res_q <= res_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  // outputs decoded from state; responses are zero outside RESPOND
  always_comb begin
    resp = state_q == S_RESPOND;
    req_ready_o = (state_q == S_IDLE && !rst_i) ? pick_grant : '0;
    dp_start_o = state_q == S_ISSUE;
    dp_operand_o = op_q;
    rsp_valid_o = resp ? NUM_REQ'(1) << gid_q : '0;
    rsp_data_o = resp ? res_q : '0;
    rsp_error_o = resp & err_q;
    grant_id_o = gid_q;
    busy_o = state_q != S_IDLE;
  end
endmodule
